// File: rtl/axi_rd_burst_issuer.sv
// AXI4 read burst issuer: turns held upstream requests into AR bursts, caps bursts in flight,
// and forwards the R channel as a stream. Define AXI_RRESP_CHECK_EN for sticky rd_error on bad rresp.
module axi_rd_burst_issuer #(
  parameter int  ADDR_W    = 64,
  parameter int  DATA_W    = 512,
  parameter int  MAX_OUTST = 8,
  localparam int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rd_req,
  input  logic [7:0]        rd_len,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              rd_req_ack,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  outst_cnt,
  output logic [31:0]       beat_count,
  output logic              rd_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  state_t state;
  logic   ar_hs;
  logic   beat;
  logic   last_beat;

  assign m_axi_rready  = dout_ready;
  assign dout_valid    = m_axi_rvalid;
  assign dout_data     = m_axi_rdata;
  assign m_axi_arsize  = 3'd6;
  assign m_axi_arburst = 2'b01;

  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign beat      = m_axi_rvalid & dout_ready;
  assign last_beat = beat & m_axi_rlast;

  // Request FSM: IDLE captures, ISSUE holds AR until accepted, ACK gives upstream one cycle to advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_axi_arvalid <= 1'b0;
      rd_req_ack    <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else begin
      rd_req_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req && (outst_cnt < MAX_CNT)) begin
            m_axi_araddr  <= rd_address;
            m_axi_arlen   <= rd_len;
            m_axi_arvalid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            rd_req_ack    <= 1'b1;
            state         <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_cnt <= '0;
    end else if (ar_hs && !last_beat) begin
      outst_cnt <= outst_cnt + 1'b1;
    end else if (last_beat && !ar_hs && (outst_cnt != '0)) begin
      outst_cnt <= outst_cnt - 1'b1;
    end
  end

  // An rlast with nothing in flight means the interconnect broke protocol
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(last_beat && !ar_hs && (outst_cnt == '0)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      beat_count <= '0;
    end else if (beat) begin
      beat_count <= beat_count + 32'd1;
    end
  end

`ifdef AXI_RRESP_CHECK_EN
  // Error beats take priority over start so a failure in the first cycle of a file is not lost
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_error <= 1'b0;
    end else if (beat && (m_axi_rresp != 2'b00)) begin
      rd_error <= 1'b1;
    end else if (start) begin
      rd_error <= 1'b0;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
  assign rd_error     = 1'b0;
`endif

endmodule
